// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game phase sequencer (menu, countdown, play, pause, over).
// Optional speed-up in PLAY when SPEEDUP_EN is defined.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous active-low reset
//   frame_tick   one-Clk pulse per video frame
//   keycode      USB HID keycode, 0 = no key
//   crash        collision level, sampled every Clk
//   menuLive     1 while in MENU
//   game_start   one-Clk pulse on COUNTDOWN->PLAY
//   difficulty   latched level 1/2/3, 0 until first selection
//   countdown    seconds remaining during COUNTDOWN
//   playing      1 in PLAY only
//   paused       1 in PAUSE only
//   game_over    1 in OVER only
//   scroll_speed road scroll pixels per frame
module game_flow_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SECS     = 3,
    parameter int OVER_FRAMES    = 180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [7:0]  keycode,
    input  logic        crash,
    output logic        menuLive,
    output logic        game_start,
    output logic [10:0] difficulty,
    output logic [3:0]  countdown,
    output logic        playing,
    output logic        paused,
    output logic        game_over,
    output logic [10:0] scroll_speed
);

    localparam int FMAX = (FRAMES_PER_SEC > OVER_FRAMES) ?
                          FRAMES_PER_SEC : OVER_FRAMES;
    localparam int CW = $clog2(FMAX + 1);
    localparam logic [CW-1:0] FPS_LAST  = CW'(FRAMES_PER_SEC - 1);
    localparam logic [CW-1:0] OVER_LAST = CW'(OVER_FRAMES - 1);
    localparam logic [3:0]    CSTART    = 4'(COUNT_SECS);

    // One-hot so the phase flags come straight off the state flops.
    typedef enum logic [4:0] {
        MENU  = 5'b00001,
        CDOWN = 5'b00010,
        PLAY  = 5'b00100,
        PAUSE = 5'b01000,
        OVER  = 5'b10000
    } state_t;

    state_t        state;
    logic [7:0]    key_prev;
    logic [CW-1:0] fcnt;
    logic          key_ev;
    logic          ev_num;
    logic          ev_p;
    logic          ev_esc;
    logic          ev_ent;
    logic          to_menu;
    logic [10:0]   num_lvl;
    logic [10:0]   play_speed;

    assign menuLive  = state[0];
    assign playing   = state[2];
    assign paused    = state[3];
    assign game_over = state[4];

`ifdef SPEEDUP_EN
    logic [9:0]  spd_cnt;
    logic [10:0] speed;
    logic [10:0] speed_inc;
    assign speed_inc  = (speed < 11'd15) ? speed + 11'd1 : speed;
    assign play_speed = speed;
`else
    assign play_speed = difficulty << 1;
`endif

    always_comb begin
        key_ev  = (keycode != 8'd0) && (keycode != key_prev);
        num_lvl = 11'd0;
        case (keycode)
            8'd30:   num_lvl = 11'd1;
            8'd31:   num_lvl = 11'd2;
            8'd32:   num_lvl = 11'd3;
            default: num_lvl = 11'd0;
        endcase
        ev_num = key_ev && (num_lvl != 11'd0);
        ev_p   = key_ev && (keycode == 8'd19);
        ev_esc = key_ev && (keycode == 8'd41);
        ev_ent = key_ev && (keycode == 8'd40);
        // Key-driven exits are checked ahead of any same-cycle tick.
        to_menu = 1'b0;
        case (state)
            CDOWN, PLAY, PAUSE: to_menu = ev_esc;
            OVER: to_menu = ev_ent ||
                            (frame_tick && (fcnt == OVER_LAST));
            default: to_menu = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= MENU;
            key_prev     <= 8'd0;
            fcnt         <= '0;
            game_start   <= 1'b0;
            difficulty   <= 11'd0;
            countdown    <= 4'd0;
            scroll_speed <= 11'd0;
`ifdef SPEEDUP_EN
            spd_cnt      <= 10'd0;
            speed        <= 11'd0;
`endif
        end else begin
            key_prev   <= keycode;
            game_start <= 1'b0;
            if (to_menu) begin
                state        <= MENU;
                countdown    <= 4'd0;
                scroll_speed <= 11'd0;
                fcnt         <= '0;
`ifdef SPEEDUP_EN
                spd_cnt      <= 10'd0;
                speed        <= 11'd0;
`endif
            end else begin
                case (state)
                    MENU: if (ev_num) begin
                        state      <= CDOWN;
                        difficulty <= num_lvl;
                        countdown  <= CSTART;
                        fcnt       <= '0;
                    end
                    CDOWN: if (frame_tick) begin
                        if (fcnt == FPS_LAST) begin
                            fcnt <= '0;
                            if (countdown == 4'd1) begin
                                state        <= PLAY;
                                countdown    <= 4'd0;
                                game_start   <= 1'b1;
                                scroll_speed <= difficulty << 1;
`ifdef SPEEDUP_EN
                                spd_cnt      <= 10'd0;
                                speed        <= difficulty << 1;
`endif
                            end else begin
                                countdown <= countdown - 4'd1;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                    PLAY: if (crash) begin
                        state        <= OVER;
                        scroll_speed <= 11'd0;
                        fcnt         <= '0;
                    end else if (ev_p) begin
                        state        <= PAUSE;
                        scroll_speed <= 11'd0;
                    end
`ifdef SPEEDUP_EN
                    else if (frame_tick) begin
                        if (spd_cnt == 10'd599) begin
                            spd_cnt      <= 10'd0;
                            speed        <= speed_inc;
                            scroll_speed <= speed_inc;
                        end else begin
                            spd_cnt <= spd_cnt + 10'd1;
                        end
                    end
`endif
                    PAUSE: if (ev_p) begin
                        state        <= PLAY;
                        scroll_speed <= play_speed;
                    end
                    OVER: if (frame_tick) begin
                        fcnt <= fcnt + 1'b1;
                    end
                    default: state <= MENU;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench for game_flow_ctrl.
// Expected outputs are queued per cycle and compared per scenario.
module tb_game_flow_ctrl;

    typedef struct packed {
        logic        menu;
        logic        gs;
        logic        ply;
        logic        pau;
        logic        ovr;
        logic [10:0] diff;
        logic [3:0]  cd;
        logic [10:0] spd;
    } obs_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  keycode = 8'd0;
    logic        crash = 1'b0;
    logic        menuLive;
    logic        game_start;
    logic [10:0] difficulty;
    logic [3:0]  countdown;
    logic        playing;
    logic        paused;
    logic        game_over;
    logic [10:0] scroll_speed;

    int checks = 0;
    int failures = 0;
    obs_t sb[$];
    obs_t got[$];

    always #5 Clk = ~Clk;

    game_flow_ctrl #(
        .FRAMES_PER_SEC(4),
        .COUNT_SECS(3),
        .OVER_FRAMES(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_tick(frame_tick),
        .keycode(keycode),
        .crash(crash),
        .menuLive(menuLive),
        .game_start(game_start),
        .difficulty(difficulty),
        .countdown(countdown),
        .playing(playing),
        .paused(paused),
        .game_over(game_over),
        .scroll_speed(scroll_speed)
    );

    function automatic obs_t mk(input logic m, input logic g,
                                input logic p, input logic z,
                                input logic o, input logic [10:0] d,
                                input logic [3:0] c,
                                input logic [10:0] s);
        obs_t r;
        r.menu = m; r.gs = g; r.ply = p; r.pau = z; r.ovr = o;
        r.diff = d; r.cd = c; r.spd = s;
        return r;
    endfunction

    // Expected PLAY speed after n ticks spent in PLAY at difficulty 3.
    function automatic logic [10:0] sp3(input int n);
`ifdef SPEEDUP_EN
        int v;
        v = 6 + n / 600;
        if (v > 15) v = 15;
        return 11'(v);
`else
        return 11'(6 + 0 * n);
`endif
    endfunction

    // Drive one cycle, queue its expectation, capture the DUT result.
    task automatic cyc(input logic t, input logic [7:0] k,
                       input logic c, input obs_t e);
        @(negedge Clk);
        frame_tick = t;
        keycode = k;
        crash = c;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        got.push_back(mk(menuLive, game_start, playing, paused,
                         game_over, difficulty, countdown,
                         scroll_speed));
    endtask

    task automatic test_reset;
        obs_t e, o;
        int n = 0;
        Reset = 1'b0;
        cyc(0, 8'd31, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        cyc(1, 8'd31, 1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        cyc(0, 8'd0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_start;
        obs_t e, o;
        int n = 0;
        repeat (10) cyc(0, 8'd31, 0, mk(0, 0, 0, 0, 0, 2, 3, 0));
        cyc(0, 8'd0, 0, mk(0, 0, 0, 0, 0, 2, 3, 0));
        for (int k = 1; k <= 12; k++) begin
            if (k < 12) begin
                e = mk(0, 0, 0, 0, 0, 2, 4'(3 - k / 4), 0);
                cyc(1, 8'd0, 0, e);
                cyc(0, 8'd0, 0, e);
            end else begin
                cyc(1, 8'd0, 0, mk(0, 1, 1, 0, 0, 2, 0, 4));
                cyc(0, 8'd0, 0, mk(0, 0, 1, 0, 0, 2, 0, 4));
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL start#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_pause;
        obs_t e, o, p, z;
        int n = 0;
        p = mk(0, 0, 1, 0, 0, 2, 0, 4);
        z = mk(0, 0, 0, 1, 0, 2, 0, 0);
        cyc(0, 8'd19, 0, z);
        cyc(0, 8'd19, 0, z);
        cyc(0, 8'd0, 1, z);
        cyc(1, 8'd0, 0, z);
        cyc(0, 8'd19, 0, p);
        cyc(0, 8'd0, 0, p);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pause#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_crash_priority;
        obs_t e, o, ov, m;
        int n = 0;
        ov = mk(0, 0, 0, 0, 1, 2, 0, 0);
        m = mk(1, 0, 0, 0, 0, 2, 0, 0);
        cyc(0, 8'd19, 1, ov);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 8'd0, 0, (k < 8) ? ov : m);
            cyc(0, 8'd0, 0, (k < 8) ? ov : m);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL crash_over#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_esc_countdown;
        obs_t e, o, m;
        int n = 0;
        m = mk(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 8'd30, 0, mk(0, 0, 0, 0, 0, 1, 3, 0));
        cyc(0, 8'd0, 0, mk(0, 0, 0, 0, 0, 1, 3, 0));
        for (int k = 1; k <= 5; k++)
            cyc(1, 8'd0, 1, mk(0, 0, 0, 0, 0, 1, 4'(3 - k / 4), 0));
        cyc(1, 8'd41, 0, m);
        cyc(1, 8'd0, 0, m);
        cyc(1, 8'd0, 1, m);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL esc_cd#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_over_enter;
        obs_t e, o, p, z, ov, m;
        int n = 0;
        p = mk(0, 0, 1, 0, 0, 3, 0, 6);
        z = mk(0, 0, 0, 1, 0, 3, 0, 0);
        ov = mk(0, 0, 0, 0, 1, 3, 0, 0);
        m = mk(1, 0, 0, 0, 0, 3, 0, 0);
        cyc(0, 8'd32, 0, mk(0, 0, 0, 0, 0, 3, 3, 0));
        cyc(0, 8'd0, 0, mk(0, 0, 0, 0, 0, 3, 3, 0));
        for (int k = 1; k < 12; k++)
            cyc(1, 8'd0, 0, mk(0, 0, 0, 0, 0, 3, 4'(3 - k / 4), 0));
        cyc(1, 8'd0, 0, mk(0, 1, 1, 0, 0, 3, 0, 6));
        cyc(0, 8'd0, 0, p);
        cyc(0, 8'd19, 0, z);
        cyc(0, 8'd0, 1, z);
        cyc(0, 8'd19, 1, p);
        cyc(0, 8'd19, 1, ov);
        repeat (3) cyc(1, 8'd0, 0, ov);
        cyc(1, 8'd40, 0, m);
        cyc(0, 8'd0, 0, m);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL over_enter#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_speed;
        obs_t e, o, z;
        int n = 0;
        int t = 0;
        z = mk(0, 0, 0, 1, 0, 3, 0, 0);
        cyc(0, 8'd32, 0, mk(0, 0, 0, 0, 0, 3, 3, 0));
        cyc(0, 8'd0, 0, mk(0, 0, 0, 0, 0, 3, 3, 0));
        for (int k = 1; k < 12; k++)
            cyc(1, 8'd0, 0, mk(0, 0, 0, 0, 0, 3, 4'(3 - k / 4), 0));
        cyc(1, 8'd0, 0, mk(0, 1, 1, 0, 0, 3, 0, 6));
        while (t < 1250) begin
            t++;
            cyc(1, 8'd0, 0, mk(0, 0, 1, 0, 0, 3, 0, sp3(t)));
        end
        cyc(0, 8'd19, 0, z);
        cyc(0, 8'd0, 0, z);
        repeat (100) cyc(1, 8'd0, 0, z);
        cyc(0, 8'd19, 0, mk(0, 0, 1, 0, 0, 3, 0, sp3(t)));
        cyc(0, 8'd0, 0, mk(0, 0, 1, 0, 0, 3, 0, sp3(t)));
        while (t < 6000) begin
            t++;
            cyc(1, 8'd0, 0, mk(0, 0, 1, 0, 0, 3, 0, sp3(t)));
        end
        cyc(1, 8'd41, 1, mk(1, 0, 0, 0, 0, 3, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL speed#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    task automatic test_midreset;
        obs_t e, o;
        int n = 0;
        cyc(0, 8'd31, 0, mk(0, 0, 0, 0, 0, 2, 3, 0));
        cyc(1, 8'd0, 0, mk(0, 0, 0, 0, 0, 2, 3, 0));
        Reset = 1'b0;
        cyc(1, 8'd0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        cyc(0, 8'd0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset#%0d got=%p want=%p", n, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_crash_priority();
        test_esc_countdown();
        test_over_enter();
        test_speed();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the menu, countdown, play, pause and game-over phases.
- Decodes keyboard keycodes into single key events.
- Latches the chosen difficulty and drives menuLive to the start-menu renderer.
- Gates road/stripe scrolling through playing and scroll_speed.
- Sits between the USB keycode path, the frame-timing source, the collision detector and the start-menu/road renderers.

Parameters:
FRAMES_PER_SEC, 60, frame_tick pulses per countdown second
COUNT_SECS, 3, countdown start value (1..15)
OVER_FRAMES, 180, frame_ticks spent in OVER before auto-return to MENU

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-low reset; state cleared on the Clk edge where Reset==0
frame_tick  in  1  one-Clk pulse per video frame
keycode  in  8  current USB HID keycode, 0 = no key
crash  in  1  level from collision detector, sampled every Clk
menuLive  out  1  1 while in MENU
game_start  out  1  one-Clk pulse on COUNTDOWN->PLAY
difficulty  out  11  latched level 1/2/3; 0 until first selection
countdown  out  4  seconds remaining, shown during COUNTDOWN
playing  out  1  1 in PLAY only
paused  out  1  1 in PAUSE only
game_over  out  1  1 in OVER only
scroll_speed  out  11  pixels per frame for the road scroller

Behaviour:
Reset:
- State = MENU. menuLive=1.
- game_start, playing, paused, game_over = 0.
- difficulty, countdown, scroll_speed = 0.
- Frame counter and key-history register cleared.
- Reset mid-operation returns to MENU on that edge.

Outputs:
- All outputs are registered.
- Each output reflects the new state one Clk after the causing input is sampled.

Key event:
- key_ev = (keycode != 0) && (keycode != key_prev). key_prev is registered every Clk.
- A held key produces exactly one event.
- Codes: 30/31/32 = digits 1/2/3, 19 = P, 41 = Esc, 40 = Enter.

States:
- MENU:
  - key_ev with 30/31/32: difficulty <= 1/2/3, countdown <= COUNT_SECS, frame counter <= 0, go to COUNTDOWN.
  - Other keys ignored.
- COUNTDOWN:
  - Each frame_tick increments the frame counter.
  - When the counter reaches FRAMES_PER_SEC-1 on a tick: counter <= 0 and countdown decrements.
  - If countdown was 1 at that tick: go to PLAY, countdown <= 0, game_start pulses for 1 Clk.
  - Esc -> MENU. crash is ignored.
- PLAY:
  - scroll_speed = difficulty<<1, giving 2/4/6.
  - Priority in one cycle: Esc -> MENU, then crash -> OVER, then P -> PAUSE.
- PAUSE:
  - scroll_speed = 0. Frame and speed-up counters are frozen.
  - P -> PLAY. Esc -> MENU. crash is ignored.
- OVER:
  - scroll_speed = 0. Counts frame_ticks from 0.
  - After OVER_FRAMES ticks -> MENU.
  - Enter key_ev -> MENU immediately.
  - difficulty is retained.

Rules on entry and conflicts:
- Entering MENU clears countdown, scroll_speed and all counters. difficulty is kept.
- A key_ev and frame_tick in the same Clk: the key transition wins and that tick is discarded.
- crash held while returning to PLAY from PAUSE: OVER on the next Clk.
- Frame counter width is clog2 of max(FRAMES_PER_SEC, OVER_FRAMES)+1. The counter never wraps past its terminal value.

Optional Feature:
SPEEDUP_EN
- Defined: in PLAY, a speed-up counter counts frame_ticks. Every 600 ticks, scroll_speed increments by 1, saturating at 15.
- The counter is reset on entry to PLAY from COUNTDOWN. It is held, not reset, across PAUSE.
- Undefined: scroll_speed is constant at difficulty<<1 in PLAY. No speed-up counter exists.

Test Plan:
1. Reset low for 2 Clk, then high -> menuLive=1, every other output 0, difficulty=0.
2. Parameters FRAMES_PER_SEC=4, COUNT_SECS=3. keycode=31 held 10 Clk -> difficulty=2 and countdown=3 once. After 12 frame_ticks: game_start single 1-Clk pulse, playing=1, scroll_speed=4.
3. In PLAY: keycode 19, then 0, then 19 -> paused=1, scroll_speed=0, then playing=1, scroll_speed=4. crash pulsed while paused -> no transition.
4. In PLAY: crash=1 and keycode=19 first seen in the same Clk -> game_over=1, not paused. With OVER_FRAMES=8, after 8 ticks -> menuLive=1, difficulty still 2.
5. In COUNTDOWN: keycode=41 coincident with frame_tick -> MENU next Clk, countdown=0, no game_start.
6. With SPEEDUP_EN, difficulty=3: 1200 ticks in PLAY -> scroll_speed=8. A pause spanning 100 ticks does not advance it. Speed saturates at 15.
